// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register peripheral.
// Holds register address map, frame geometry and the frame FSM state type.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    // Bit counter saturates here; any count above FRAME_BITS marks overrun.
    localparam logic [4:0] CNT_OVERRUN = 5'd17;

    localparam int ADDR_EN_OUT_LO = 'h00;
    localparam int ADDR_EN_OUT_HI = 'h01;
    localparam int ADDR_EN_PWM_LO = 'h02;
    localparam int ADDR_EN_PWM_HI = 'h03;
    localparam int ADDR_PWM_DUTY  = 'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchronizer with edge detection for an asynchronous pin.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   din_i     - asynchronous input pin
//   level_o   - synchronized level
//   rise_o    - one-cycle pulse on a 0->1 transition of level_o
//   fall_o    - one-cycle pulse on a 1->0 transition of level_o
// RST_VAL sets the idle level so that no spurious edge appears after reset.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target decoding 16-bit write frames into control registers
// for the downstream PWM/output stage. SCLK is oversampled as data.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   ncs, sclk, copi   - asynchronous SPI pins
//   cipo, cipo_oe     - SPI data out and its enable (readback build only)
//   en_reg_*, pwm_duty_cycle - register file outputs, addresses 0x00..0x04
// Build option: define SPI_REG_READBACK_EN to enable read frames on cipo.
//
// state  | meaning
// IDLE   | waiting for ncs to fall
// SHIFT  | frame in progress, sampling copi on sclk rising edges
// COMMIT | one cycle after ncs rose; write register if frame is valid
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       copi,
    output logic       cipo,
    output logic       cipo_oe,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    // ncs idles high, so its synchronizer resets high to avoid a false fall.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din_i(ncs),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din_i(copi),
        .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    spi_state_e state_q, state_d;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic [7:0]  regs_q [NUM_REGS];

    logic       shift_en, frame_start, commit_we;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       addr_ok;

    assign wr_addr = shift_q[14:8];
    assign wr_data = shift_q[7:0];
    assign addr_ok = (32'(wr_addr) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = COMMIT;
            // A new frame may start while the previous one commits.
            COMMIT:  state_d = ncs_fall ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // ncs level is already high on an ncs_rise cycle, so a coincident
        // sclk_rise is excluded here.
        shift_en    = (state_q == SHIFT) && sclk_rise && !ncs_lvl;
        frame_start = ncs_fall && ((state_q == IDLE) || (state_q == COMMIT));
        commit_we   = (state_q == COMMIT) && (cnt_q == 5'(FRAME_BITS))
                      && shift_q[15] && addr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[14:0], copi_lvl};
            if (cnt_q != CNT_OVERRUN) cnt_q <= cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit_we) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_addr == 7'(i)) regs_q[i] <= wr_data;
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];

`ifdef SPI_REG_READBACK_EN
    logic [7:0] tx_q;
    logic [7:0] rd_data;
    logic [6:0] rd_addr;
    logic       rd_rw;
    logic       tx_load, tx_shift;

    // On the 8th sclk rise the header completes with the bit being sampled.
    assign rd_rw   = shift_q[6];
    assign rd_addr = {shift_q[5:0], copi_lvl};
    assign tx_load = shift_en && (cnt_q == 5'd7);
    // The fall right after bit 8 must keep the MSB on the line, so shifting
    // starts only once the master has sampled it (count 9 onward).
    assign tx_shift = (state_q == SHIFT) && sclk_fall && !ncs_lvl
                      && (cnt_q >= 5'd9);

    always_comb begin
        rd_data = regs_q[ADDR_EN_OUT_LO];
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 7'(i)) rd_data = regs_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) tx_q <= '0;
        else if (tx_load)       tx_q <= rd_rw ? 8'h00 : rd_data;
        else if (tx_shift)      tx_q <= {tx_q[6:0], 1'b0};
    end

    assign cipo    = tx_q[7];
    assign cipo_oe = ~ncs_lvl;

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: table of write frames with expected
// register images, plus hand sequences for mid-frame reset and readback.
module tb_spi_reg_peripheral;

    logic       clk = 1'b0;
    logic       rst, ncs, sclk, copi;
    logic       cipo, cipo_oe;
    logic [7:0] r0, r1, r2, r3, r4;
    logic [39:0] regs_all;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_reg_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1),
        .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle(r4)
    );

    assign regs_all = {r4, r3, r2, r1, r0};

    typedef struct {
        string        name;
        logic [16:0]  frame;
        int           nbits;
        logic [39:0]  exp;     // {0x04, 0x03, 0x02, 0x01, 0x00}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [16:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    // Sends one frame and checks the exact commit latency: old image three
    // clocks after ncs rises, new image on the fourth.
    task automatic send_frame(input string name, input logic [16:0] val, input int nbits,
                              input logic [39:0] prev, input logic [39:0] exp);
        check({name, "_pre"}, regs_all, prev);
        ncs = 1'b0;
        tick(4);
        shift_bits(val, nbits);
        tick(4);
        ncs = 1'b1;
        tick(3);
        check({name, "_hold"}, regs_all, prev);
        tick(1);
        check(name, regs_all, exp);
        tick(8);
        check({name, "_stable"}, regs_all, exp);
    endtask

    initial begin
        logic [39:0] prev;
        logic [7:0]  rb;

        vecs[0]  = '{"wr_a01",     17'h08155, 16, 40'h00_00_00_55_00};
        vecs[1]  = '{"wr_a04_ff",  17'h084FF, 16, 40'hFF_00_00_55_00};
        vecs[2]  = '{"wr_a04_80",  17'h08480, 16, 40'h80_00_00_55_00};
        vecs[3]  = '{"rw0_drop",   17'h00233, 16, 40'h80_00_00_55_00};
        vecs[4]  = '{"a0a_drop",   17'h08A77, 16, 40'h80_00_00_55_00};
        vecs[5]  = '{"short15",    17'h0414C, 15, 40'h80_00_00_55_00};
        vecs[6]  = '{"over17",     17'h10532, 17, 40'h80_00_00_55_00};
        vecs[7]  = '{"wr_a00",     17'h08011, 16, 40'h80_00_00_55_11};
        vecs[8]  = '{"wr_a03",     17'h08304, 16, 40'h80_04_00_55_11};
        vecs[9]  = '{"a05_drop",   17'h08505, 16, 40'h80_04_00_55_11};
        vecs[10] = '{"wr_a02",     17'h08299, 16, 40'h80_04_99_55_11};

        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        check("reset_regs", regs_all, 40'h0);
        check("reset_cipo", {39'h0, cipo}, 40'h0);
        check("reset_cipo_oe", {39'h0, cipo_oe}, 40'h0);

        prev = 40'h0;
        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].name, vecs[v].frame, vecs[v].nbits, prev, vecs[v].exp);
            prev = vecs[v].exp;
        end

        // Reset after 9 bits of 0x83AA: registers clear, partial frame is lost.
        ncs = 1'b0;
        tick(4);
        shift_bits(17'h00107, 9);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("midrst_clear", regs_all, 40'h0);
        tick(4);
        ncs = 1'b1;
        tick(10);
        check("midrst_after", regs_all, 40'h0);
        send_frame("wr_83aa", 17'h083AA, 16, 40'h0, 40'h00_AA_00_00_00);
        prev = 40'h00_AA_00_00_00;

`ifdef SPI_REG_READBACK_EN
        send_frame("wr_8266", 17'h08266, 16, prev, 40'h00_AA_66_00_00);
        prev = 40'h00_AA_66_00_00;
        check("rb_oe_idle", {39'h0, cipo_oe}, 40'h0);
        ncs = 1'b0;
        tick(4);
        check("rb_oe_active", {39'h0, cipo_oe}, 40'h1);
        shift_bits(17'h00002, 8);
        rb = 8'h66;
        for (int b = 7; b >= 0; b--) begin
            copi = 1'b0;
            tick(4);
            check($sformatf("rb_bit%0d", b), {39'h0, cipo}, {39'h0, rb[b]});
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        ncs = 1'b1;
        tick(6);
        check("rb_oe_end", {39'h0, cipo_oe}, 40'h0);
        check("rb_regs_kept", regs_all, prev);
`else
        ncs = 1'b0;
        tick(4);
        shift_bits(17'h00002, 8);
        check("nrb_cipo", {39'h0, cipo}, 40'h0);
        check("nrb_cipo_oe", {39'h0, cipo_oe}, 40'h0);
        shift_bits(17'h00000, 8);
        tick(4);
        ncs = 1'b1;
        tick(8);
        check("nrb_regs_kept", regs_all, prev);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
